button_conditioner: RTL
=======================

# button_conditioner

Front-end conditioning stage between a raw board push-button and the LED fill-pattern sequencer that consumes a clean `button` start signal. Synchronizes the asynchronous pin, debounces it with a programmable stability window, and produces a clean level plus single-cycle press, release and long-press event pulses. It also keeps a wrapping press counter for debug LEDs.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive sampled cycles the input must differ from the current level before the level flips; must be ≥1.
- `LONG_PRESS_CYCLES`, default 16: cycles the debounced level must stay high before a long-press event; must be ≥2.
- `clk` in 1: clock; all state on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `button_raw` in 1: raw pin; asynchronous and bouncy.
- `button_level` out 1: debounced level.
- `press_pulse` out 1: one cycle high on a debounced 0→1 transition; feeds the sequencer's `button`.
- `release_pulse` out 1: one cycle high on a debounced 1→0 transition.
- `long_press_pulse` out 1: one cycle high when the hold reaches `LONG_PRESS_CYCLES`.
- `press_count` out 8: number of press events, modulo 256.

## Operation

- Synchronizer: 2 flops, s1 ← `button_raw` and s2 ← s1. Reset value 0.
- Debounce counter, width clog2(`DEBOUNCE_CYCLES`), minimum 1 bit. Behaviour each edge:
  - If s2 == level: counter ← 0.
  - Else if counter == `DEBOUNCE_CYCLES`−1: level ← s2 and counter ← 0.
  - Else: counter ← counter+1.
- Glitch filtering: a difference lasting fewer than `DEBOUNCE_CYCLES` sampled cycles never changes the level. Any return to the old value restarts the count from 0.
- Event pulses are registered, so all outputs come straight from flops:
  - `press_pulse` is high in exactly the first cycle that `button_level` reads 1.
  - `release_pulse` is high in exactly the first cycle that `button_level` reads 0 after having been 1.
- Hold counter:
  - Cleared while the level is 0.
  - Counts the cycles the level is high, saturating at `LONG_PRESS_CYCLES`.
  - `long_press_pulse` is high in the `LONG_PRESS_CYCLES`-th consecutive high cycle, counting the `press_pulse` cycle as cycle 1. It fires once per press, with no auto-repeat.
  - Releasing before that cycle produces no long-press event.
- `press_count` increments in the `press_pulse` cycle and wraps 255→0.
- Pulse exclusivity:
  - `press_pulse` and `release_pulse` are never high together.
  - `long_press_pulse` never coincides with `press_pulse`, because `LONG_PRESS_CYCLES` ≥ 2.

## Timing

- Reset: all outputs, synchronizer flops, debounce counter and hold counter are 0, and take that value immediately on `rst` assertion.
- Press latency: `button_raw` changes and then stays stable. `button_level` and `press_pulse` first read the new state after the (`DEBOUNCE_CYCLES`+2)-th rising edge following the change. This is 2 edges of synchronizer plus `DEBOUNCE_CYCLES` edges of debounce; 6 edges with the defaults.
- Release latency is identical.
- Reset mid-operation:
  - All state is discarded and no pulses appear during reset.
  - If `button_raw` is still high after deassertion, a fresh press is detected `DEBOUNCE_CYCLES`+2 edges later.
- Simultaneous events: a level flip and a counter restart cannot coincide, because the counter only advances while s2 ≠ level.
- Saturation: the hold counter stays at `LONG_PRESS_CYCLES` for as long as the level remains high; no further events occur.

## Structure

- Shared package holds:
  - Default constants `DEBOUNCE_CYCLES_DEF=4`, `LONG_PRESS_CYCLES_DEF=16`.
  - The `press_count` width constant `PRESS_CNT_W=8`.
- One sub-module, `sync_2ff`: a generic 1-bit, two-flop synchronizer with asynchronous active-high reset to 0, reused for other board inputs.
- The debounce, edge-detection and hold logic stay in the top module.

## Test plan

Defaults unless noted (`DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16).

- Reset: assert `rst` with `button_raw`=1 → all outputs 0. Deassert → `button_level`=1 and `press_pulse`=1 (one cycle) after the 6th edge, and `press_count`=1.
- Clean press held 10 cycles, then release:
  - `press_pulse` once.
  - `release_pulse` once, 10 cycles after `press_pulse`.
  - No `long_press_pulse`.
- Bounce: raw toggles 1,0,1,0 with a 2-cycle period, then stays 1 → exactly one `press_pulse`, 6 edges after the last transition.
- Glitch: a 3-cycle high pulse on raw → `button_level` stays 0 and no pulses occur.
- Long press: hold 40 cycles → `long_press_pulse` exactly once, 15 cycles after `press_pulse`; then a single `release_pulse`.
- Counter wrap: 256 clean presses → `press_count` returns to 0. Mid-press `rst` → `press_count`=0 and no stray `release_pulse`.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioning front end.
package button_conditioner_pkg;
  localparam int DEBOUNCE_CYCLES_DEF   = 4;
  localparam int LONG_PRESS_CYCLES_DEF = 16;
  localparam int PRESS_CNT_W           = 8;
endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw push-button, producing a clean level plus
// registered press, release and long-press pulses and a wrapping press counter.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   button_raw,
  output logic                   button_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic              s2;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              level_next;
  logic              flip;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s2)
  );

  // Any sample agreeing with the current level restarts the stability window.
  always_comb begin
    flip        = 1'b0;
    level_next  = button_level;
    db_cnt_next = db_cnt;
    if (s2 == button_level) begin
      db_cnt_next = '0;
    end else if (db_cnt == DB_MAX) begin
      level_next  = s2;
      db_cnt_next = '0;
      flip        = 1'b1;
    end else begin
      db_cnt_next = db_cnt + 1'b1;
    end
  end

  // Hold count is computed from the next level so the press cycle counts as 1.
  always_comb begin
    hold_cnt_next = '0;
    if (level_next) begin
      hold_cnt_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_level     <= 1'b0;
      db_cnt           <= '0;
      hold_cnt         <= '0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= '0;
    end else begin
      button_level     <= level_next;
      db_cnt           <= db_cnt_next;
      hold_cnt         <= hold_cnt_next;
      press_pulse      <= flip & s2;
      release_pulse    <= flip & ~s2;
      long_press_pulse <= (hold_cnt_next == HOLD_MAX) && (hold_cnt != HOLD_MAX);
      if (flip && s2) begin
        press_count <= press_count + PRESS_CNT_W'(1);
      end
    end
  end
endmodule
